// File: rtl/ninjakun_pkg.sv
// Shared definitions for the Ninja-Kun shared work RAM arbiter.
// Holds the FSM state encoding and the default RAM window width.
package ninjakun_pkg;

  localparam int SHRAM_ABITS = 11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

endpackage

// File: rtl/ninjakun_shram_arb_if.sv
// Two CPU buses plus the single-port RAM side of the shared RAM arbiter.
// slave: arbiter view; master: CPU/RAM environment view.
interface ninjakun_shram_arb_if #(
  parameter int ABITS = 11
);
  logic             REQ0;
  logic             WE0;
  logic [ABITS-1:0] AD0;
  logic [7:0]       OD0;
  logic             WAIT0;
  logic [7:0]       ID0;
  logic             REQ1;
  logic             WE1;
  logic [ABITS-1:0] AD1;
  logic [7:0]       OD1;
  logic             WAIT1;
  logic [7:0]       ID1;
  logic [ABITS-1:0] RAD;
  logic [7:0]       RWD;
  logic             RWE;
  logic [7:0]       RRD;

  modport slave (
    input  REQ0, WE0, AD0, OD0,
    input  REQ1, WE1, AD1, OD1,
    input  RRD,
    output WAIT0, ID0, WAIT1, ID1,
    output RAD, RWD, RWE
  );

  modport master (
    output REQ0, WE0, AD0, OD0,
    output REQ1, WE1, AD1, OD1,
    output RRD,
    input  WAIT0, ID0, WAIT1, ID1,
    input  RAD, RWD, RWE
  );
endinterface

// File: rtl/ninjakun_arb_port.sv
// Per-CPU port state: served flag, latched read data, pend/stall.
// Ports: clk, rst, req, set_srv, ld, rrd -> pend, stall, id.
module ninjakun_arb_port
  import ninjakun_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       set_srv,
  input  logic       ld,
  input  logic [7:0] rrd,
  output logic       pend,
  output logic       stall,
  output logic [7:0] id
);

  logic srv;

  // A low request always clears, even on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srv <= 1'b0;
    end else if (!req) begin
      srv <= 1'b0;
    end else if (set_srv) begin
      srv <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id <= 8'h00;
    end else if (ld) begin
      id <= rrd;
    end
  end

  assign pend  = req & ~srv;
  assign stall = req & ~srv;

endmodule

// File: rtl/ninjakun_shram_arb.sv
// Round-robin arbiter for main/sub CPU access to the shared work RAM.
// Ports: ARBCL, RESET, bus (CPU0/CPU1 request side and RAM side).
module ninjakun_shram_arb
  import ninjakun_pkg::*;
#(
  parameter int ABITS = SHRAM_ABITS,
  parameter int RLAT  = 1
) (
  input  logic ARBCL,
  input  logic RESET,
  ninjakun_shram_arb_if.slave bus
);

  generate
    if (RLAT < 1 || RLAT > 3) begin : g_bad_rlat
      $error("ninjakun_shram_arb: RLAT must be 1..3");
    end
  endgenerate

  localparam logic [1:0] CNT0 = 2'(RLAT - 1);

  logic [0:0]       state;
  logic             gnt;
  logic             last;
  logic [1:0]       cnt;
  logic             wel;
  logic [ABITS-1:0] rad;
  logic [7:0]       rwd;
  logic             rwe;

  logic pend0, pend1;
  logic pick;
  logic done, rd_done;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      pend0 & ~pend1: pick = 1'b0;
      ~pend0 & pend1: pick = 1'b1;
      default:        pick = ~last;
    endcase
  end

  assign done    = (state == ST_ACC) & (wel | (cnt == 2'd0));
  assign rd_done = done & ~wel;

  always_ff @(posedge ARBCL or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= 2'd0;
      wel   <= 1'b0;
      rad   <= '0;
      rwd   <= 8'h00;
      rwe   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pend0 | pend1) begin
            gnt   <= pick;
            rad   <= pick ? bus.AD1 : bus.AD0;
            rwd   <= pick ? bus.OD1 : bus.OD0;
            rwe   <= pick ? bus.WE1 : bus.WE0;
            wel   <= pick ? bus.WE1 : bus.WE0;
            cnt   <= CNT0;
            state <= ST_ACC;
          end
        end
        ST_ACC: begin
          rwe <= 1'b0;
          if (done) begin
            last  <= gnt;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ninjakun_arb_port u_p0 (
    .clk     (ARBCL),
    .rst     (RESET),
    .req     (bus.REQ0),
    .set_srv (done & ~gnt),
    .ld      (rd_done & ~gnt),
    .rrd     (bus.RRD),
    .pend    (pend0),
    .stall   (bus.WAIT0),
    .id      (bus.ID0)
  );

  ninjakun_arb_port u_p1 (
    .clk     (ARBCL),
    .rst     (RESET),
    .req     (bus.REQ1),
    .set_srv (done & gnt),
    .ld      (rd_done & gnt),
    .rrd     (bus.RRD),
    .pend    (pend1),
    .stall   (bus.WAIT1),
    .id      (bus.ID1)
  );

  assign bus.RAD = rad;
  assign bus.RWD = rwd;
  assign bus.RWE = rwe;

endmodule
